// File: rtl/arbiter_wrr_if.sv
// Request/acknowledge/weight bundle and registered grant outputs of the
// weighted round-robin arbiter; state_dbg exposes the FSM state for checkers.
interface arbiter_wrr_if #(
  parameter int PORTS        = 4,
  parameter int WEIGHT_WIDTH = 4
);
  localparam int IDX_W = $clog2(PORTS);

  logic [PORTS-1:0]              request;
  logic [PORTS-1:0]              acknowledge;
  logic [PORTS*WEIGHT_WIDTH-1:0] weight;
  logic [PORTS-1:0]              grant;
  logic                          grant_valid;
  logic [IDX_W-1:0]              grant_encoded;
  logic                          timeout;
  logic                          state_dbg;

  modport master (
    output request, acknowledge, weight,
    input  grant, grant_valid, grant_encoded, timeout, state_dbg
  );

  modport slave (
    input  request, acknowledge, weight,
    output grant, grant_valid, grant_encoded, timeout, state_dbg
  );
endinterface

// File: rtl/arbiter_wrr.sv
// Weighted round-robin arbiter with registered one-hot grant and per-grant credit.
// Optional forced release of a stalled holder: define ARBITER_WRR_TIMEOUT_EN.
//
// Handshake: request is a level held by a port for as long as it wants the
// grant; acknowledge is a one-cycle pulse per completed transfer and only
// counts for the port currently shown on grant. A grant ends when its credit
// is spent, its request drops, or (optionally) it stalls; the next winner is
// loaded at that same edge.
module arbiter_wrr #(
  parameter int PORTS                 = 4,
  parameter int WEIGHT_WIDTH          = 4,
  parameter int ARB_LSB_HIGH_PRIORITY = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  arbiter_wrr_if.slave bus
);
  localparam int IDX_W = $clog2(PORTS);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_GRANTED = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [PORTS-1:0]        grant_q, grant_d;
  logic [PORTS-1:0]        mask_q, mask_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [WEIGHT_WIDTH-1:0] credit_q, credit_d;

  logic                    load;
  logic                    expire;
  logic                    holder_ack;
  logic                    holder_req;
  logic                    release_now;
  logic [PORTS-1:0]        req_masked;
  logic [PORTS-1:0]        cand;
  logic [IDX_W-1:0]        win;
  logic [WEIGHT_WIDTH-1:0] win_weight;
  logic [PORTS-1:0]        win_mask;

  function automatic logic [IDX_W-1:0] pick(input logic [PORTS-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    if (ARB_LSB_HIGH_PRIORITY != 0) begin
      for (int i = PORTS - 1; i >= 0; i--) begin
        if (v[i]) r = IDX_W'(i);
      end
    end else begin
      for (int i = 0; i < PORTS; i++) begin
        if (v[i]) r = IDX_W'(i);
      end
    end
    return r;
  endfunction

  // Ports that come after the winner in rotation order.
  function automatic logic [PORTS-1:0] mask_after(input logic [IDX_W-1:0] w);
    logic [PORTS-1:0] m;
    m = '0;
    for (int j = 0; j < PORTS; j++) begin
      if (ARB_LSB_HIGH_PRIORITY != 0) m[j] = (j > int'(w));
      else                            m[j] = (j < int'(w));
    end
    return m;
  endfunction

  always_comb begin
    req_masked = bus.request & mask_q;
    cand       = (|req_masked) ? req_masked : bus.request;
    win        = pick(cand);
    win_weight = bus.weight[int'(win)*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    win_mask   = mask_after(win);
  end

  assign holder_ack  = bus.acknowledge[idx_q];
  assign holder_req  = bus.request[idx_q];
  assign release_now = !holder_req
                     || (holder_ack && (credit_q == WEIGHT_WIDTH'(1)))
                     || expire;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    mask_d   = mask_q;
    idx_d    = idx_q;
    credit_d = credit_q;
    load     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|bus.request) load = 1'b1;
      end
      ST_GRANTED: begin
        if (release_now) begin
          if (|bus.request) begin
            load = 1'b1;
          end else begin
            state_d  = ST_IDLE;
            grant_d  = '0;
            idx_d    = '0;
            credit_d = '0;
          end
        end else if (holder_ack) begin
          credit_d = credit_q - WEIGHT_WIDTH'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Weight is sampled only here; a zero weight still buys one transfer.
    if (load) begin
      state_d  = ST_GRANTED;
      grant_d  = PORTS'(1) << win;
      idx_d    = win;
      mask_d   = win_mask;
      credit_d = (win_weight == '0) ? WEIGHT_WIDTH'(1) : win_weight;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      mask_q   <= '1;
      idx_q    <= '0;
      credit_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      mask_q   <= mask_d;
      idx_q    <= idx_d;
      credit_q <= credit_d;
    end
  end

`ifdef ARBITER_WRR_TIMEOUT_EN
  logic [3:0] hold_cnt_q, hold_cnt_d;
  logic       timeout_q, timeout_d;

  // Expiry on the 16th held cycle without an acknowledge from the holder.
  assign expire = (state_q == ST_GRANTED) && (hold_cnt_q == 4'd15) && !holder_ack;

  always_comb begin
    hold_cnt_d = '0;
    timeout_d  = expire && holder_req;
    if (load || holder_ack)            hold_cnt_d = '0;
    else if (state_q == ST_GRANTED)    hold_cnt_d = hold_cnt_q + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign expire      = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  assign bus.grant         = grant_q;
  assign bus.grant_valid   = (state_q == ST_GRANTED);
  assign bus.grant_encoded = idx_q;
  assign bus.state_dbg     = state_q;
endmodule

// File: tb/tb_arbiter_wrr.sv
// Directed bench for arbiter_wrr: LSB-priority instance under full checking,
// plus an MSB-priority instance fed the same inputs for the alternation case.
module tb_arbiter_wrr;
  localparam int P  = 4;
  localparam int WW = 4;

  logic clk;
  logic rst_n;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  arbiter_wrr_if #(.PORTS(P), .WEIGHT_WIDTH(WW)) bus ();
  arbiter_wrr_if #(.PORTS(P), .WEIGHT_WIDTH(WW)) bus_m ();

  assign bus_m.request     = bus.request;
  assign bus_m.acknowledge = bus.acknowledge;
  assign bus_m.weight      = bus.weight;

  arbiter_wrr #(.PORTS(P), .WEIGHT_WIDTH(WW), .ARB_LSB_HIGH_PRIORITY(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  arbiter_wrr #(.PORTS(P), .WEIGHT_WIDTH(WW), .ARB_LSB_HIGH_PRIORITY(0)) dut_msb (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_m)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n           = 1'b0;
    bus.request     = '0;
    bus.acknowledge = '0;
    bus.weight      = {4'd1, 4'd1, 4'd1, 4'd1};
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_grant(input string tag, input int port);
    check_eq({tag, "_grant"}, 32'(bus.grant), 32'(1) << port);
    check_eq({tag, "_enc"},   32'(bus.grant_encoded), 32'(port));
    check_eq({tag, "_valid"}, 32'(bus.grant_valid), 32'd1);
  endtask

  initial begin
    logic [31:0] e;

    // Reset values
    do_reset();
    #1;
    check_eq("rst_grant",   32'(bus.grant), 32'd0);
    check_eq("rst_valid",   32'(bus.grant_valid), 32'd0);
    check_eq("rst_enc",     32'(bus.grant_encoded), 32'd0);
    check_eq("rst_timeout", 32'(bus.timeout), 32'd0);
    check_eq("rst_state",   32'(bus.state_dbg), 32'd0);

    // Two requesters, weight 1, ack every cycle: LSB 0,2,0 and MSB 2,0,2
    bus.request     = 4'b0101;
    bus.acknowledge = 4'b1111;
    step();
    check_grant("alt0", 0);
    check_eq("alt0_msb", 32'(bus_m.grant_encoded), 32'd2);
    step();
    check_grant("alt1", 2);
    check_eq("alt1_msb", 32'(bus_m.grant_encoded), 32'd0);
    step();
    check_grant("alt2", 0);
    check_eq("alt2_msb", 32'(bus_m.grant_encoded), 32'd2);
    bus.request     = '0;
    bus.acknowledge = '0;
    step();
    check_eq("idle_valid", 32'(bus.grant_valid), 32'd0);
    check_eq("idle_grant", 32'(bus.grant), 32'd0);

    // Weights {3,1,2,1} on ports 0..3, all requesting, ack every cycle
    do_reset();
    bus.weight      = {4'd1, 4'd2, 4'd1, 4'd3};
    bus.request     = 4'b1111;
    bus.acknowledge = 4'b1111;
    exp_q = '{0, 0, 0, 1, 2, 2, 3, 0, 0, 0, 1};
    while (exp_q.size() > 0) begin
      step();
      e = exp_q.pop_front();
      check_grant("wrr", int'(e));
    end

    // Weight 0 behaves as 1: a single ack releases and regrants with no gap
    do_reset();
    bus.weight      = {4'd1, 4'd1, 4'd0, 4'd1};
    bus.request     = 4'b0010;
    step();
    check_grant("w0_first", 1);
    bus.acknowledge = 4'b0010;
    step();
    check_grant("w0_regrant", 1);
    bus.request     = 4'b1010;
    step();
    check_grant("w0_move", 3);

    // Early release on request drop; weight changes mid-grant are ignored
    do_reset();
    bus.weight      = {4'd1, 4'd5, 4'd1, 4'd1};
    bus.request     = 4'b0100;
    step();
    check_grant("drop_g2", 2);
    bus.weight      = {4'd1, 4'd1, 4'd1, 4'd1};
    bus.request     = 4'b1100;
    bus.acknowledge = 4'b0100;
    step();
    check_grant("drop_ack1", 2);
    step();
    check_grant("drop_ack2", 2);
    bus.request     = 4'b1000;
    bus.acknowledge = 4'b0000;
    step();
    check_grant("drop_move", 3);

    // Asynchronous reset mid-grant, then pure-priority first grant
    do_reset();
    bus.request = 4'b0010;
    step();
    check_grant("ar_pre", 1);
    rst_n = 1'b0;
    #2;
    check_eq("ar_grant", 32'(bus.grant), 32'd0);
    check_eq("ar_valid", 32'(bus.grant_valid), 32'd0);
    check_eq("ar_enc",   32'(bus.grant_encoded), 32'd0);
    bus.request = 4'b0101;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_grant("ar_first", 0);

    // Holder keeps requesting without acknowledging
    do_reset();
    bus.request = 4'b0010;
    step();
    check_grant("hold_g", 1);
    for (int k = 1; k <= 20; k++) begin
      step();
      check_grant("hold", 1);
`ifdef ARBITER_WRR_TIMEOUT_EN
      check_eq("hold_timeout", 32'(bus.timeout), (k == 16) ? 32'd1 : 32'd0);
`else
      check_eq("hold_timeout", 32'(bus.timeout), 32'd0);
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/arbiter_wrr.md
# arbiter_wrr

Weighted round-robin arbiter: the parametrised successor to the plain round-robin arbiter, used in front of shared muxes (e.g. `axis_arb_mux`-style datapaths). Each port has a runtime-programmable weight, the number of acknowledged transfers it may complete per grant before the grant rotates. Grants are registered, held across multiple acknowledges, and released early if the holder drops its request.

## Interface
- `PORTS`, default 4: number of requesters, 2 to 32.
- `WEIGHT_WIDTH`, default 4: width of each per-port weight field.
- `ARB_LSB_HIGH_PRIORITY`, default 0: 1 means the lowest index wins on ties; 0 means the highest index wins.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `request`  in  PORTS  per-port request, level.
- `acknowledge`  in  PORTS  per-port transfer-complete pulse; counted only for the granted port.
- `weight`  in  PORTS*WEIGHT_WIDTH  packed weights; port i uses bits [i*WEIGHT_WIDTH +: WEIGHT_WIDTH].
- `grant`  out  PORTS  one-hot grant, registered.
- `grant_valid`  out  1  high when any grant bit is set.
- `grant_encoded`  out  $clog2(PORTS)  index of the granted port; 0 when idle.
- `timeout`  out  1  one-cycle pulse on a forced release (see Configuration).

## Operation
- State: `grant_reg`, `credit` (WEIGHT_WIDTH bits), round-robin `mask` (PORTS bits).
- States:
  - IDLE: `grant_valid` = 0.
  - GRANTED: one port is held.
- IDLE -> GRANTED when any `request` bit is set.
- Winner selection:
  - Pick from `request & mask`.
  - If that is empty, pick from `request`.
  - Priority within the set follows `ARB_LSB_HIGH_PRIORITY`.
- On a grant to port i:
  - `credit` loads weight[i]; a weight of 0 is treated as 1.
  - `mask` is set to the ports after i in the rotation (above i for LSB mode, below i for MSB mode).
  - `weight` is sampled only at grant time; changes during a grant are ignored.
- In GRANTED, on `acknowledge[i]`:
  - `credit` decrements.
  - If `credit` was 1, this is a release.
- In GRANTED, `request[i]` low is a release regardless of `credit`.
- Acknowledges on non-granted ports are ignored.
- On release, the next winner is chosen at the same edge:
  - If other ports are requesting, the grant moves directly to the next winner with no idle cycle.
  - If the releasing port is the only requester and is still requesting, it is re-granted with fresh credit.
  - If nothing is requesting, the block goes to IDLE.
- Simultaneous `acknowledge[i]` with `credit` = 1 and `request[i]` low counts as a single release.

## Timing
- Reset (asynchronous assert, synchronous deassert at the use site):
  - `grant` = 0, `grant_valid` = 0, `grant_encoded` = 0, `timeout` = 0, `credit` = 0.
  - `mask` = all ones, so the first arbitration is pure priority.
- A request sampled at edge n produces a grant visible after edge n; latency is 1 cycle.
- Release and regrant take effect at the same edge; throughput is one grant change per cycle.
- `grant`, `grant_valid` and `grant_encoded` are always consistent in the same cycle.
- Reset asserted mid-grant clears everything immediately; the pending credit is lost.

## Configuration
- `ARBITER_WRR_TIMEOUT_EN` defined:
  - A 16-cycle hold counter restarts on every grant load and on every acknowledge from the holder.
  - When it expires with no acknowledge, the grant is force-released as a normal release.
  - `timeout` pulses high for exactly 1 cycle, the cycle after the release edge.
- `ARBITER_WRR_TIMEOUT_EN` not defined:
  - The counter is not built.
  - `timeout` is tied to 0.
  - A grant is held indefinitely while the holder keeps requesting without acknowledging.

## Test plan
- Reset, then `request` = 4'b0101 with all weights 1, LSB mode, acknowledging every cycle -> grants alternate port 0, port 2, port 0; `grant_encoded` = 0, 2, 0.
- Weights {3,1,2,1} with `request` = 4'b1111, ack each cycle, LSB mode -> grant sequence 0,0,0,1,2,2,3 then repeats.
- Weight 0 on port 1, only port 1 requesting -> a single ack releases and immediately regrants port 1 with no `grant_valid` gap.
- Port 2 granted with weight 5; drop `request[2]` after 2 acks while port 3 requests -> `grant` = 4'b1000 on the next edge.
- `rst_n` low mid-grant -> all outputs go to 0 asynchronously; after deassert the first grant goes to the highest-priority requester.
- With `ARBITER_WRR_TIMEOUT_EN`: hold port 1 requesting with no ack -> release after 16 cycles, one `timeout` pulse, regrant to port 1 if it is the sole requester.
